// File: rtl/rs_dispatch_ctrl.sv
// Credit-based in-order dispatch from decode lanes into reservation stations.
// Tracks free RS entries per station and registers accepted lanes to the RS.
module rs_dispatch_ctrl #(
   parameter int DISPATCH_WIDTH = 2,
   parameter int RS_NUM         = 4,
   parameter int RS_SIZE        = 8,
   parameter int TAG_W          = 7,
   localparam int RS_W = (RS_NUM > 1) ? $clog2(RS_NUM) : 1,
   localparam int CW   = $clog2(RS_SIZE + 1)
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 flush_i,
   input  logic [DISPATCH_WIDTH-1:0]            in_valid_i,
   input  logic [DISPATCH_WIDTH-1:0][RS_W-1:0]  in_rs_sel_i,
   input  logic [DISPATCH_WIDTH-1:0][TAG_W-1:0] in_tag_i,
   output logic [DISPATCH_WIDTH-1:0]            in_ready_o,
   input  logic [RS_NUM-1:0][1:0]               rel_cnt_i,
   output logic [DISPATCH_WIDTH-1:0]            out_valid_o,
   output logic [DISPATCH_WIDTH-1:0][RS_W-1:0]  out_rs_o,
   output logic [DISPATCH_WIDTH-1:0][TAG_W-1:0] out_tag_o,
   output logic [RS_NUM-1:0][CW-1:0]            credit_o,
   output logic [31:0]                          stall_cnt_o,
   output logic                                 err_o
);

   typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_e;

   state_e                              state_q, state_d;
   logic [RS_NUM-1:0][CW-1:0]           credit_q, credit_d;
   logic                                err_q, err_d;
   logic [31:0]                         stall_q, stall_d;
   logic [DISPATCH_WIDTH-1:0]           rdy, acc;
   logic [DISPATCH_WIDTH-1:0]           out_valid_q;
   logic [DISPATCH_WIDTH-1:0][RS_W-1:0] out_rs_q;
   logic [DISPATCH_WIDTH-1:0][TAG_W-1:0] out_tag_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= RUN;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (flush_i)  state_d = FLUSH;
         FLUSH:   if (!flush_i) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   // A lane needs more credit than the older lanes already took from its RS
   always_comb begin : p_ready
      logic go;
      int   same;
      rdy  = '0;
      go   = 1'b1;
      same = 0;
      if (state_q == RUN && !flush_i) begin
         for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            same = 0;
            for (int j = 0; j < i; j++)
               if (in_rs_sel_i[j] == in_rs_sel_i[i]) same++;
            rdy[i] = go && (int'(credit_q[in_rs_sel_i[i]]) > same);
            go     = go & rdy[i] & in_valid_i[i];
         end
      end
   end

   assign acc = rdy & in_valid_i;

   always_comb begin : p_credit
      int sum;
      credit_d = credit_q;
      err_d    = err_q;
      sum      = 0;
      for (int r = 0; r < RS_NUM; r++) begin
         if (flush_i || state_q == FLUSH) begin
            credit_d[r] = CW'(RS_SIZE);
         end else begin
            sum = int'(credit_q[r]) + int'(rel_cnt_i[r]);
            for (int i = 0; i < DISPATCH_WIDTH; i++)
               if (acc[i] && in_rs_sel_i[i] == RS_W'(r)) sum--;
            if (sum > RS_SIZE) begin
               credit_d[r] = CW'(RS_SIZE);
               err_d       = 1'b1;
            end else begin
               credit_d[r] = CW'(sum);
            end
         end
      end
   end

   always_comb begin
      stall_d = stall_q;
      if (state_q == RUN && in_valid_i[0] && !rdy[0] && stall_q != '1)
         stall_d = stall_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < RS_NUM; r++) credit_q[r] <= CW'(RS_SIZE);
         err_q       <= 1'b0;
         stall_q     <= '0;
         out_valid_q <= '0;
         out_rs_q    <= '0;
         out_tag_q   <= '0;
      end else begin
         credit_q    <= credit_d;
         err_q       <= err_d;
         stall_q     <= stall_d;
         out_valid_q <= acc;
         for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            if (acc[i]) begin
               out_rs_q[i]  <= in_rs_sel_i[i];
               out_tag_q[i] <= in_tag_i[i];
            end
         end
      end
   end

   assign in_ready_o  = rdy;
   assign out_valid_o = out_valid_q;
   assign out_rs_o    = out_rs_q;
   assign out_tag_o   = out_tag_q;
   assign credit_o    = credit_q;
   assign stall_cnt_o = stall_q;
   assign err_o       = err_q;

endmodule

// File: doc/rs_dispatch_ctrl.md
RS_DISPATCH_CTRL -- requirements
Module: rs_dispatch_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning): DISPATCH_WIDTH, 2, dispatch lanes per cycle; RS_NUM, 4, reservation stations served; RS_SIZE, 8, entries per RS; TAG_W, 7, payload tag width.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk, input, 1: clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- flush_i, input, 1: pipeline flush.
- in_valid_i, input, DISPATCH_WIDTH: lane valid; lanes are compacted and program-ordered, lane 0 oldest.
- in_rs_sel_i, input, DISPATCH_WIDTH x clog2(RS_NUM): target RS per lane.
- in_tag_i, input, DISPATCH_WIDTH x TAG_W: tag per lane.
- in_ready_o, output, DISPATCH_WIDTH: lane accepted if valid.
- rel_cnt_i, input, RS_NUM x 2: entries freed per RS this cycle, range 0..2.
- out_valid_o, output, DISPATCH_WIDTH: registered dispatch strobe to the RS.
- out_rs_o, output, DISPATCH_WIDTH x clog2(RS_NUM): registered RS index.
- out_tag_o, output, DISPATCH_WIDTH x TAG_W: registered tag.
- credit_o, output, RS_NUM x clog2(RS_SIZE+1): current free-entry credit per RS.
- stall_cnt_o, output, 32: dispatch stall counter.
- err_o, output, 1: sticky credit-overflow error.

Function
REQ-003 SHALL keep one credit counter per RS with range 0..RS_SIZE, meaning RS entries not yet claimed.
REQ-004 SHALL implement a 2-state FSM, RUN and FLUSH:
- RUN goes to FLUSH on flush_i.
- FLUSH goes to RUN after exactly 1 cycle, unless flush_i is high again, in which case it stays in FLUSH.
REQ-005 In RUN, in_ready_o[i] SHALL be 1 iff all of the following hold:
- in_ready_o[j] & in_valid_i[j] for every j<i;
- credit[in_rs_sel_i[i]] > count of lanes j<i accepted to the same RS.
REQ-006 In FLUSH, or with flush_i high, in_ready_o SHALL be all zero.
REQ-007 Accept rule: lane i is accepted iff in_valid_i[i] & in_ready_o[i]. An invalid or blocked lane SHALL block all higher lanes (strict in-order, no lane skipping).
REQ-008 Per-cycle credit update: credit[r]_next = credit[r] - accepted_to_r + rel_cnt_i[r].
REQ-009 Credits released in cycle N SHALL NOT be used for acceptance before cycle N+1.
REQ-010 If the REQ-008 sum would exceed RS_SIZE, the credit SHALL saturate at RS_SIZE and err_o SHALL set; err_o stays set until reset.
REQ-011 Credit subtraction SHALL never underflow, which REQ-005 guarantees.
REQ-012 Output timing: out_valid_o[i], out_rs_o[i] and out_tag_o[i] SHALL be registered from accepted lane i with 1-cycle latency.
- Lanes not accepted give out_valid_o[i]=0.
- out_rs_o and out_tag_o hold their previous values when out_valid_o[i]=0.
REQ-013 The output has no backpressure; a claimed credit guarantees the RS has space.
REQ-014 On flush_i, in the next cycle:
- all credits SHALL be RS_SIZE;
- out_valid_o SHALL be 0;
- rel_cnt_i SHALL be ignored during the flush_i cycle and the FLUSH cycle.
REQ-015 flush_i SHALL take priority over simultaneous accepts and releases.
REQ-016 stall_cnt_o SHALL increment by 1 in each RUN cycle where in_valid_i[0]=1 and in_ready_o[0]=0.
- It saturates at 2^32-1.
- It is not cleared by flush.
REQ-017 credit_o SHALL equal the registered credit values.

Reset
REQ-018 When rst_n is low, asynchronously:
- credits = RS_SIZE;
- state = RUN;
- out_valid_o = 0, out_rs_o = 0, out_tag_o = 0;
- stall_cnt_o = 0, err_o = 0.
REQ-019 Reset asserted mid-operation SHALL discard all in-flight dispatches. The first cycle after deassertion SHALL accept normally.

Verification
REQ-020 Basic dispatch: reset; lanes {valid, rs=1, tag=5} and {valid, rs=2, tag=6} -> in_ready_o=11; next cycle out_valid_o=11, out_tag_o={6,5}, credit[1]=7, credit[2]=7.
REQ-021 Full RS: drive 8 single-lane dispatches to rs=3 -> credit[3]=0. A 9th dispatch sees in_ready_o[0]=0 and stall_cnt_o increments each cycle. rel_cnt_i[3]=1 in cycle N gives acceptance in N+1, not N.
REQ-022 Same-RS contention: credit[0]=1; both lanes target rs=0 -> in_ready_o=01; lane 1 is held; credit[0]=0.
REQ-023 Lane blocking: lane 0 targets a full RS and lane 1 targets an empty RS -> in_ready_o=00, with no lane skipping.
REQ-024 Flush: with credit[2]=3, assert flush_i together with valid lanes -> no accept; next cycle credits are all 8, out_valid_o=0, FSM is in FLUSH and in_ready_o=00; the cycle after, accepts resume.
REQ-025 Overflow: at credit[1]=8, drive rel_cnt_i[1]=2 -> credit[1] stays 8 and err_o=1 until rst_n is low.
